// File: rtl/bridge_top.sv
// bridge_top: AHB-to-APB bridge with three APB slaves at 0x8000_0000, 0x8400_0000 and 0x8800_0000.
// Optional feature: define BRIDGE_ERR_RESP_EN to answer out-of-range AHB transfers with an ERROR response.
module bridge_top (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RENABLE,
      ST_WWAIT,
      ST_WRITE,
      ST_WRITEP,
      ST_WENABLE,
      ST_WENABLEP
   } state_t;

   typedef struct packed {
      logic [SW-1:0] psel;
      logic          penable;
      logic          pwrite;
      logic [AW-1:0] paddr;
      logic [DW-1:0] pwdata;
      logic          hready;
   } apb_out_t;

   localparam apb_out_t APB_RST = '{
      psel:    SW'(0),
      penable: 1'b0,
      pwrite:  1'b0,
      paddr:   AW'(0),
      pwdata:  DW'(0),
      hready:  1'b1
   };

   state_t        state_q, state_d;
   apb_out_t      apb_q, apb_d;
   logic [AW-1:0] haddr1_q, haddr2_q;
   logic [DW-1:0] hwdata1_q;
   logic          hwritereg_q;
   logic [SW-1:0] tempselx_c;
   logic          valid_c;

   // One-hot slave decode on the top six address bits (64 MB windows).
   function automatic logic [SW-1:0] slave_sel(input logic [AW-1:0] addr);
      logic [SW-1:0] sel;
      sel = SW'(0);
      if (addr[31:26] == 6'b100000) begin
         sel = 3'b001;
      end else if (addr[31:26] == 6'b100001) begin
         sel = 3'b010;
      end else if (addr[31:26] == 6'b100010) begin
         sel = 3'b100;
      end
      return sel;
   endfunction

   assign tempselx_c = slave_sel(Haddr);
   assign valid_c    = Hreadyin && ((Htrans == 2'b10) || (Htrans == 2'b11)) && (tempselx_c != SW'(0));

   // Address needs two pipeline stages (write data is one phase behind); write data needs one.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         haddr1_q    <= AW'(0);
         haddr2_q    <= AW'(0);
         hwdata1_q   <= DW'(0);
         hwritereg_q <= 1'b0;
      end else begin
         haddr1_q    <= Haddr;
         haddr2_q    <= haddr1_q;
         hwdata1_q   <= Hwdata;
         hwritereg_q <= Hwrite;
      end
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q <= ST_IDLE;
         apb_q   <= APB_RST;
      end else begin
         state_q <= state_d;
         apb_q   <= apb_d;
      end
   end

   // Next state and the APB/ready values that accompany each transition.
   always_comb begin
      state_d = state_q;
      apb_d   = apb_q;
      unique case (state_q)
         ST_IDLE, ST_RENABLE, ST_WENABLE: begin
            if (valid_c && !Hwrite) begin
               state_d       = ST_READ;
               apb_d.paddr   = Haddr;
               apb_d.pwrite  = 1'b0;
               apb_d.psel    = tempselx_c;
               apb_d.penable = 1'b0;
               apb_d.hready  = 1'b0;
            end else begin
               state_d       = valid_c ? ST_WWAIT : ST_IDLE;
               apb_d.psel    = SW'(0);
               apb_d.penable = 1'b0;
               apb_d.hready  = 1'b1;
            end
         end
         ST_READ: begin
            state_d       = ST_RENABLE;
            apb_d.penable = 1'b1;
            apb_d.hready  = 1'b1;
         end
         ST_WRITEP: begin
            state_d       = ST_WENABLEP;
            apb_d.penable = 1'b1;
            apb_d.hready  = 1'b1;
         end
         ST_WRITE: begin
            state_d       = valid_c ? ST_WENABLEP : ST_WENABLE;
            apb_d.penable = 1'b1;
            apb_d.hready  = 1'b1;
         end
         ST_WWAIT: begin
            // Write data arrives now, one cycle after its address.
            state_d       = valid_c ? ST_WRITEP : ST_WRITE;
            apb_d.paddr   = haddr1_q;
            apb_d.pwdata  = Hwdata;
            apb_d.pwrite  = 1'b1;
            apb_d.psel    = slave_sel(haddr1_q);
            apb_d.penable = 1'b0;
            apb_d.hready  = 1'b0;
         end
         ST_WENABLEP: begin
            // Pipelined transfer: the pending beat has moved two address stages deep.
            if (!hwritereg_q) begin
               state_d = ST_READ;
            end else begin
               state_d = valid_c ? ST_WRITEP : ST_WRITE;
            end
            apb_d.paddr   = haddr2_q;
            apb_d.pwdata  = hwdata1_q;
            apb_d.pwrite  = hwritereg_q;
            apb_d.psel    = slave_sel(haddr2_q);
            apb_d.penable = 1'b0;
            apb_d.hready  = 1'b0;
         end
      endcase
   end

`ifdef BRIDGE_ERR_RESP_EN
   logic [1:0] hresp_q;

   // ERROR for one cycle after an active transfer that hits no slave.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         hresp_q <= 2'b00;
      end else if (Hreadyin && ((Htrans == 2'b10) || (Htrans == 2'b11)) && (tempselx_c == SW'(0))) begin
         hresp_q <= 2'b01;
      end else begin
         hresp_q <= 2'b00;
      end
   end

   assign Hresp = hresp_q;
`else
   assign Hresp = 2'b00;
`endif

   assign Hrdata    = Prdata;
   assign Hreadyout = apb_q.hready;
   assign Pselx     = apb_q.psel;
   assign Penable   = apb_q.penable;
   assign Pwrite    = apb_q.pwrite;
   assign Paddr     = apb_q.paddr;
   assign Pwdata    = apb_q.pwdata;

endmodule

// File: tb/tb_bridge_top.sv
// tb_bridge_top: AHB master model driving bridge_top, APB scoreboard and Hresp reference model.
module tb_bridge_top;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;
`ifdef BRIDGE_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        Hclk;
   logic        Hreset;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;

   bridge_top dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Htrans    (Htrans),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Prdata    (Prdata),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   typedef struct {
      logic [1:0]  htrans;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      logic [2:0]  exp_psel;
   } vec_t;

   typedef struct {
      logic [2:0]  psel;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic [31:0] rdata;
   } apb_exp_t;

   localparam int NV = 11;
   vec_t        tbl [NV];
   apb_exp_t    sb_q [$];
   apb_exp_t    e;
   logic [31:0] seq_addr [4];
   logic [31:0] seq_data [4];

   int          n_pass = 0;
   int          n_total = 0;
   bit          mon_en;
   logic [1:0]  exp_hresp;
   bit          prev_setup;
   logic [2:0]  prev_psel;
   logic        prev_pwrite;
   logic [31:0] prev_paddr;
   logic [31:0] prev_pwdata;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (a < 32'h8C00_0000);
   endfunction

   // Output monitor: Hresp model, APB phase discipline, scoreboard pop on each enable cycle.
   always @(negedge Hclk) begin
      if (mon_en) begin
         check("hresp", 128'(Hresp), 128'(exp_hresp));
         exp_hresp = (!Hreset && ERR_EN && Hreadyin && Htrans[1] && !in_range(Haddr)) ? 2'b01 : 2'b00;
         if (Pselx != 3'b000 && !Penable) begin
            check("hready_setup", 128'(Hreadyout), 128'(0));
         end
         if (Pselx != 3'b000 && Penable) begin
            check("setup_then_enable", 128'(prev_setup && prev_psel == Pselx && prev_pwrite == Pwrite &&
                                            prev_paddr == Paddr && prev_pwdata == Pwdata), 128'(1));
            check("hready_enable", 128'(Hreadyout), 128'(1));
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL apb_unexpected: got access psel=%b addr=0x%h, expected none", Pselx, Paddr);
            end else begin
               e = sb_q.pop_front();
               check("apb_psel", 128'(Pselx), 128'(e.psel));
               check("apb_pwrite", 128'(Pwrite), 128'(e.pwrite));
               check("apb_paddr", 128'(Paddr), 128'(e.paddr));
               if (e.pwrite) check("apb_pwdata", 128'(Pwdata), 128'(e.pwdata));
               else          check("hrdata", 128'(Hrdata), 128'(e.rdata));
            end
         end
         prev_setup  = (Pselx != 3'b000) && !Penable;
         prev_psel   = Pselx;
         prev_pwrite = Pwrite;
         prev_paddr  = Paddr;
         prev_pwdata = Pwdata;
      end
   end

   // AHB master with Hready looped back: beats advance only when the bridge is ready.
   task automatic run_seq(input logic wr, input int n, input logic [1:0] first);
      int   a = 0;
      int   cyc = 0;
      logic rdy;
      while (a <= n && cyc < 64) begin
         Hreadyin = Hreadyout;
         Hwrite   = wr;
         if (a < n) begin
            Htrans = (a == 0) ? first : T_SEQ;
            Haddr  = seq_addr[a];
         end else begin
            Htrans = T_IDLE;
            Haddr  = 32'h0;
         end
         Hwdata = (a > 0 && wr) ? seq_data[a-1] : 32'h0;
         rdy    = Hreadyout;
         @(posedge Hclk); #1;
         if (rdy) a++;
         cyc++;
      end
      check("beats_accepted", 128'(a), 128'(n + 1));
      for (int i = 0; i < 6; i++) begin
         Hreadyin = Hreadyout;
         Htrans   = T_IDLE;
         Haddr    = 32'h0;
         Hwdata   = 32'h0;
         @(posedge Hclk); #1;
      end
   endtask

   task automatic push_and_run(input logic wr, input int n, input logic [2:0] psel);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back('{psel, wr, seq_addr[i], seq_data[i], Prdata});
      end
      run_seq(wr, n, T_NSEQ);
      check("burst_drained", 128'(sb_q.size()), 128'(0));
   endtask

   initial begin
      Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = T_IDLE;
      Haddr = 32'h0; Hwdata = 32'h0; Prdata = 32'h0;
      mon_en = 1'b0; exp_hresp = 2'b00; prev_setup = 1'b0;
      prev_psel = 3'b000; prev_pwrite = 1'b0; prev_paddr = 32'h0; prev_pwdata = 32'h0;

      tbl[0]  = '{T_NSEQ, 1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 32'h0,          3'b001};
      tbl[1]  = '{T_NSEQ, 1'b0, 32'h8400_0020, 32'h0,          32'h1234_5678, 3'b010};
      tbl[2]  = '{T_NSEQ, 1'b1, 32'h8800_0100, 32'hDEAD_BEEF, 32'h0,          3'b100};
      tbl[3]  = '{T_SEQ,  1'b0, 32'h8BFF_FFFC, 32'h0,          32'h0F0F_0F0F, 3'b100};
      tbl[4]  = '{T_NSEQ, 1'b1, 32'h83FF_FFFC, 32'h1122_3344, 32'h0,          3'b001};
      tbl[5]  = '{T_NSEQ, 1'b0, 32'h87FF_FFFC, 32'h0,          32'h55AA_55AA, 3'b010};
      tbl[6]  = '{T_BUSY, 1'b1, 32'h8000_0020, 32'h7777_7777, 32'h0,          3'b000};
      tbl[7]  = '{T_NSEQ, 1'b1, 32'h9000_0000, 32'h6666_6666, 32'h0,          3'b000};
      tbl[8]  = '{T_NSEQ, 1'b0, 32'h7FFF_FFFC, 32'h0,          32'h4444_4444, 3'b000};
      tbl[9]  = '{T_NSEQ, 1'b0, 32'h8C00_0000, 32'h0,          32'h3333_3333, 3'b000};
      tbl[10] = '{T_IDLE, 1'b1, 32'h8000_0000, 32'h2222_2222, 32'h0,          3'b000};

      repeat (2) @(posedge Hclk);
      #1;
      check("rst_pselx", 128'(Pselx), 128'(0));
      check("rst_penable", 128'(Penable), 128'(0));
      check("rst_pwrite", 128'(Pwrite), 128'(0));
      check("rst_paddr", 128'(Paddr), 128'(0));
      check("rst_pwdata", 128'(Pwdata), 128'(0));
      check("rst_hreadyout", 128'(Hreadyout), 128'(1));
      check("rst_hresp", 128'(Hresp), 128'(0));
      Hreset = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < NV; i++) begin
         Prdata      = tbl[i].prdata;
         seq_addr[0] = tbl[i].addr;
         seq_data[0] = tbl[i].wdata;
         if (tbl[i].exp_psel != 3'b000) begin
            sb_q.push_back('{tbl[i].exp_psel, tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].prdata});
         end
         run_seq(tbl[i].write, 1, tbl[i].htrans);
         check("row_drained", 128'(sb_q.size()), 128'(0));
      end

      // INCR4 write burst
      for (int i = 0; i < 4; i++) begin
         seq_addr[i] = 32'h8800_0000 + 32'(4 * i);
         seq_data[i] = 32'hC0DE_0000 + 32'(i);
      end
      push_and_run(1'b1, 4, 3'b100);

      // WRAP4 write burst
      seq_addr[0] = 32'h8000_0038; seq_addr[1] = 32'h8000_003C;
      seq_addr[2] = 32'h8000_0030; seq_addr[3] = 32'h8000_0034;
      for (int i = 0; i < 4; i++) seq_data[i] = 32'hBEEF_0010 + 32'(i);
      push_and_run(1'b1, 4, 3'b001);

      // INCR4 read burst
      Prdata = 32'hCAFE_F00D;
      for (int i = 0; i < 4; i++) begin
         seq_addr[i] = 32'h8400_0100 + 32'(4 * i);
         seq_data[i] = 32'h0;
      end
      push_and_run(1'b0, 4, 3'b010);

      // Reset while a read sits in its setup cycle
      Hreadyin = 1'b1; Hwrite = 1'b0; Htrans = T_NSEQ; Haddr = 32'h8400_0020;
      @(posedge Hclk); #1;
      check("midrd_setup_psel", 128'(Pselx), 128'(3'b010));
      Hreset = 1'b1; Htrans = T_IDLE; Haddr = 32'h0;
      @(posedge Hclk); #1;
      check("midrd_rst_pselx", 128'(Pselx), 128'(0));
      check("midrd_rst_penable", 128'(Penable), 128'(0));
      check("midrd_rst_hreadyout", 128'(Hreadyout), 128'(1));
      Hreset = 1'b0;
      @(posedge Hclk); #1;
      check("midrd_idle_pselx", 128'(Pselx), 128'(0));
      check("midrd_idle_penable", 128'(Penable), 128'(0));

      // Normal operation after the aborted transfer
      Prdata      = 32'h0BAD_F00D;
      seq_addr[0] = 32'h8000_0004;
      seq_data[0] = 32'h0;
      push_and_run(1'b0, 1, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
